drive_sched: RTL
================

# drive_sched

Periodic evaluation controller for the desiredDrive assist-current datapath in the eBike drive chain. Every TICK_DIV clocks it snapshots the rider/sensor inputs, launches one multi-cycle desiredDrive evaluation over a start/done handshake, and slew-limits the result into the applied target current. It also enforces a hard zero for not-pedaling and for assist-disable, and latches a sticky fault if the core never answers.

## Interface
- TICK_DIV, 1024: clocks between evaluation launches; must exceed CORE_TIMEOUT+4.
- SLEW_STEP, 12'h040: maximum change of target_curr per evaluation.
- CORE_TIMEOUT, 15: maximum cycles spent waiting for dd_done.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  assist enable.
- avg_torque / cadence / not_pedaling / incline / scale  in  12/5/1/13/3  live sensor inputs.
- dd_avg_torque / dd_cadence / dd_not_pedaling / dd_incline / dd_scale  out  12/5/1/13/3  snapshot registers feeding the datapath.
- dd_start  out  1  one-cycle launch pulse.
- dd_done  in  1  core result valid.
- dd_target_curr  in  12  core result, sampled only with dd_done.
- target_curr  out  12  slew-limited applied target.
- tgt_vld  out  1  one-cycle pulse, coincident with each target_curr update.
- fault  out  1  sticky core-timeout flag.

## Operation
- Tick counter: free-running 0..TICK_DIV-1, wraps; tick = (count == TICK_DIV-1).
- IDLE:
  - tick with fault=1: ignored; stay in IDLE.
  - tick with en=0: raw=0, go to SLEW; no launch, no snapshot.
  - tick with en=1: snapshot all five inputs.
    - snapshot not_pedaling=1: go to ZERO.
    - otherwise: go to LAUNCH.
- LAUNCH: dd_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - dd_done=1: raw=dd_target_curr; go to SLEW.
  - Wait counter reaches CORE_TIMEOUT-1 with no done: set fault; go to ZERO. If done and the limit coincide, done wins.
- SLEW:
  - raw>cur: cur += min(raw-cur, SLEW_STEP).
  - raw<cur: cur -= min(cur-raw, SLEW_STEP).
  - raw==cur: cur unchanged.
  - Pulse tgt_vld; go to IDLE.
  - Unsigned 12-bit arithmetic; no wrap is possible because the step is clamped to the difference.
- ZERO: cur=0 immediately, bypassing slew; pulse tgt_vld; go to IDLE.
- Ticks that occur outside IDLE are dropped; they are never queued.
- dd_done outside WAIT is ignored.
- fault clears only on rst.

## Timing
- Reset values:
  - All outputs 0, including the snapshots, dd_start, target_curr, tgt_vld and fault.
  - State IDLE; tick counter 0.
  - First tick occurs TICK_DIV-1 cycles after rst deasserts.
- Edge sequence for a normal evaluation:
  - Tick edge: snapshot, IDLE to LAUNCH.
  - dd_start is high for the following cycle.
  - WAIT begins the next cycle.
- Result latency: dd_done sampled at edge E moves state to SLEW. target_curr and tgt_vld become visible after edge E+1 and stay for one cycle; target_curr then holds.
- Timeout: WAIT lasts at most CORE_TIMEOUT cycles. fault and the zeroed target appear 2 edges after the last WAIT cycle.
- Snapshot outputs hold stable from the snapshot edge until the next snapshot.
- rst asserted mid-operation aborts immediately; a pending dd_done is discarded.

## Structure
- Shared package drive_pkg holds:
  - State enum: IDLE, LAUNCH, WAIT, SLEW, ZERO.
  - Width constants: TORQUE_W=12, CAD_W=5, INCL_W=13, SCALE_W=3, CURR_W=12.
- Sub-module slew_lim: combinational next-value computation from cur, raw and SLEW_STEP.

## Test plan
All scenarios use TICK_DIV=64, CORE_TIMEOUT=15, SLEW_STEP=12'h040, and a bench core model that answers with dd_done 5 cycles after dd_start.

- Basic launch: torque 12'h800, cadence 5'h10, incline 13'h0150, scale 3; core returns 12'hA1A.
  - First dd_start 64 cycles after reset; snapshots match the inputs.
  - target_curr steps 040, 080, … A00, then A1A on the 41st evaluation; one tgt_vld per evaluation.
- Ramp down: cur=12'h100; core returns 12'h080 → target_curr 0C0, then 080, then holds 080.
- Not pedaling: cur=12'hD66; not_pedaling=1 at tick → no dd_start; target_curr=000 with tgt_vld in the same evaluation.
- Timeout: core never asserts dd_done → fault=1 and target_curr=000 after 15 WAIT cycles. No further dd_start over 3 ticks; rst clears fault.
- Disable: cur=12'h0C0, en=0 → no dd_start; target_curr goes 080, 040, 000 on successive ticks, then holds 000, with tgt_vld each tick.
- Reset mid-WAIT: assert rst in the 3rd WAIT cycle, then let the core's dd_done arrive → all outputs 0, dd_done ignored, next dd_start 64 cycles after release.

Source files
------------

// File: rtl/drive_pkg.sv
// drive_pkg: shared state encoding and datapath widths for drive_sched
package drive_pkg;
    localparam int TORQUE_W = 12;
    localparam int CAD_W    = 5;
    localparam int INCL_W   = 13;
    localparam int SCALE_W  = 3;
    localparam int CURR_W   = 12;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SLEW, ZERO} state_t;
endpackage

// File: rtl/drive_sched_slew_lim.sv
// slew_lim: next applied current, moving cur toward raw by at most STEP
module slew_lim import drive_pkg::*; #(
    parameter logic [CURR_W-1:0] STEP = 12'h040
) (
    input  logic [CURR_W-1:0] cur,
    input  logic [CURR_W-1:0] raw,
    output logic [CURR_W-1:0] nxt
);
    logic [CURR_W-1:0] up;
    logic [CURR_W-1:0] dn;
    // step is clamped to the remaining distance, so neither direction can wrap
    always_comb begin
        up  = raw - cur;
        dn  = cur - raw;
        nxt = raw > cur ? (up > STEP ? cur + STEP : raw) : (dn > STEP ? cur - STEP : raw);
    end
endmodule

// File: rtl/drive_sched.sv
// drive_sched: periodic desiredDrive launch, result slew limiting and core-timeout fault
module drive_sched import drive_pkg::*; #(
    parameter int                TICK_DIV     = 1024,
    parameter logic [CURR_W-1:0] SLEW_STEP    = 12'h040,
    parameter int                CORE_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [TORQUE_W-1:0] avg_torque,
    input  logic [CAD_W-1:0]    cadence,
    input  logic                not_pedaling,
    input  logic [INCL_W-1:0]   incline,
    input  logic [SCALE_W-1:0]  scale,
    output logic [TORQUE_W-1:0] dd_avg_torque,
    output logic [CAD_W-1:0]    dd_cadence,
    output logic                dd_not_pedaling,
    output logic [INCL_W-1:0]   dd_incline,
    output logic [SCALE_W-1:0]  dd_scale,
    output logic                dd_start,
    input  logic                dd_done,
    input  logic [CURR_W-1:0]   dd_target_curr,
    output logic [CURR_W-1:0]   target_curr,
    output logic                tgt_vld,
    output logic                fault
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int WW = $clog2(CORE_TIMEOUT + 1);
    state_t            state;
    logic [TW-1:0]     cnt;
    logic [WW-1:0]     wcnt;
    logic [CURR_W-1:0] raw;
    logic [CURR_W-1:0] nxt;
    logic              tmo;
    logic              tick;
    assign tick = cnt == TW'(TICK_DIV - 1);
    slew_lim #(.STEP(SLEW_STEP)) u_slew (.cur(target_curr), .raw(raw), .nxt(nxt));
    // free-running evaluation period counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
    // evaluation sequencer; tmo carries a timeout into ZERO so fault and the zeroed target land together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wcnt            <= '0;
            raw             <= '0;
            tmo             <= 1'b0;
            dd_avg_torque   <= '0;
            dd_cadence      <= '0;
            dd_not_pedaling <= 1'b0;
            dd_incline      <= '0;
            dd_scale        <= '0;
            dd_start        <= 1'b0;
            target_curr     <= '0;
            tgt_vld         <= 1'b0;
            fault           <= 1'b0;
        end else begin
            dd_start <= 1'b0;
            tgt_vld  <= 1'b0;
            case (state)
                IDLE: if (tick && !fault) begin
                    if (!en) begin
                        raw   <= '0;
                        state <= SLEW;
                    end else begin
                        dd_avg_torque   <= avg_torque;
                        dd_cadence      <= cadence;
                        dd_not_pedaling <= not_pedaling;
                        dd_incline      <= incline;
                        dd_scale        <= scale;
                        dd_start        <= !not_pedaling;
                        state           <= not_pedaling ? ZERO : LAUNCH;
                    end
                end
                LAUNCH: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: if (dd_done) begin
                    raw   <= dd_target_curr;
                    state <= SLEW;
                end else if (wcnt == WW'(CORE_TIMEOUT - 1)) begin
                    tmo   <= 1'b1;
                    state <= ZERO;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                SLEW: begin
                    target_curr <= nxt;
                    tgt_vld     <= 1'b1;
                    state       <= IDLE;
                end
                ZERO: begin
                    target_curr <= '0;
                    tgt_vld     <= 1'b1;
                    fault       <= fault | tmo;
                    tmo         <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
